// File: rtl/pipeline_types.sv
// Shared types for the branch redirect path: resolved branches, predictor updates, redirect FSM states.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package pipeline_types;

    // One resolved branch from an execute pipe.
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
        logic        pred_taken;
        logic [31:0] pred_target;
    } branch_resolve_t;

    // One training record for the branch predictor.
    typedef struct packed {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
        logic        mispredict;
    } bpu_update_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REDIR = 2'd1,
        DRAIN = 2'd2
    } redir_state_t;

    // Direction wrong, or taken with the wrong target. A not-taken branch never
    // mispredicts on target alone.
    function automatic logic is_mispredict(input branch_resolve_t b);
        return b.valid && ((b.taken != b.pred_taken) ||
                           (b.taken && (b.target != b.pred_target)));
    endfunction

    // Correct fetch address after this branch; pc+4 wraps at 32 bits.
    function automatic logic [31:0] redirect_target(input branch_resolve_t b);
        return b.taken ? b.target : (b.pc + 32'd4);
    endfunction

    function automatic bpu_update_t to_update(input branch_resolve_t b);
        bpu_update_t u;
        u.pc         = b.pc;
        u.taken      = b.taken;
        u.target     = b.target;
        u.mispredict = is_mispredict(b);
        return u;
    endfunction

endpackage

// File: rtl/branch_redirect_ctrl_if.sv
// Bundle of execute, frontend-redirect and predictor-update signals around branch_redirect_ctrl.
// Latency: n/a (wires only).
// Backpressure: redirect_ready_i / upd_ready_i from consumers, stall_o towards execute.
interface branch_redirect_ctrl_if;
    import pipeline_types::*;

    branch_resolve_t [1:0] br_i;             // index 0 is the older instruction
    logic                  stall_o;
    logic                  redirect_valid_o;
    logic [31:0]           redirect_pc_o;
    logic                  redirect_ready_i;
    logic                  flush_o;
    logic                  kill_younger_o;
    bpu_update_t           upd_o;
    logic                  upd_valid_o;
    logic                  upd_ready_i;
    logic [31:0]           perf_branch_cnt_o;
    logic [31:0]           perf_mispred_cnt_o;

    // Controller side.
    modport slave (
        input  br_i, redirect_ready_i, upd_ready_i,
        output stall_o, redirect_valid_o, redirect_pc_o, flush_o, kill_younger_o,
               upd_o, upd_valid_o, perf_branch_cnt_o, perf_mispred_cnt_o
    );

    // Environment side: execute, frontend and predictor.
    modport master (
        output br_i, redirect_ready_i, upd_ready_i,
        input  stall_o, redirect_valid_o, redirect_pc_o, flush_o, kill_younger_o,
               upd_o, upd_valid_o, perf_branch_cnt_o, perf_mispred_cnt_o
    );

endinterface

// File: rtl/branch_update_fifo.sv
// 2-write / 1-read FIFO of predictor update records, DEPTH entries (power of 2).
// Latency: a pushed entry is visible at the head one cycle after the push.
// Backpressure: none internally; the writer must keep >=2 free entries (o_free) before pushing.
module branch_update_fifo
    import pipeline_types::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_wr0_vld,
    input  bpu_update_t            i_wr0_dat,
    input  logic                   i_wr1_vld,   // only together with i_wr0_vld
    input  bpu_update_t            i_wr1_dat,
    output logic                   o_rd_vld,
    output bpu_update_t            o_rd_dat,
    input  logic                   i_rd_rdy,
    output logic [$clog2(DEPTH):0] o_free
);

    localparam int AW = $clog2(DEPTH);

    bpu_update_t   r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic [1:0]    w_wr_n;
    logic          w_pop;

    assign w_wr_n   = {1'b0, i_wr0_vld} + {1'b0, i_wr1_vld};
    assign w_pop    = o_rd_vld && i_rd_rdy;
    assign o_rd_vld = (r_count != '0);
    // Head is forced to zero when empty so the port never shows stale data.
    assign o_rd_dat = o_rd_vld ? r_mem[r_rptr] : '0;
    assign o_free   = (AW+1)'(DEPTH) - r_count;

    // Storage: slot 0 lands at the write pointer, slot 1 right behind it.
    always_ff @(posedge clk) begin
        if (i_wr0_vld) r_mem[r_wptr]          <= i_wr0_dat;
        if (i_wr1_vld) r_mem[r_wptr + AW'(1)] <= i_wr1_dat;
    end

    // Pointers wrap naturally at DEPTH; occupancy moves by pushes minus pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            r_wptr  <= r_wptr + AW'(w_wr_n);
            r_rptr  <= r_rptr + AW'(w_pop);
            r_count <= r_count + (AW+1)'(w_wr_n) - (AW+1)'(w_pop);
        end
    end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Resolves two branches per cycle, redirects the frontend on a mispredict and queues predictor updates.
// Latency: flush/kill same cycle as detection; redirect_valid_o one cycle later; updates visible next cycle.
// Backpressure: stall_o while a redirect is pending/draining or fewer than 2 FIFO slots are free.
// Optional: define BRANCH_PERF_CNT_EN for saturating branch / mispredict counters.
module branch_redirect_ctrl
    import pipeline_types::*;
#(
    parameter int UPD_DEPTH    = 4,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    branch_redirect_ctrl_if.slave bus
);

    localparam int FREE_W = $clog2(UPD_DEPTH) + 1;
    localparam int CNT_W  = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    redir_state_t      r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_redirect_valid;
    logic [31:0]       r_redirect_pc;

    logic [FREE_W-1:0] w_free;
    logic              w_stall;
    logic              w_accept;
    logic              w_mis0;
    logic              w_mis1;
    logic              w_push0;
    logic              w_push1;
    logic              w_wr0_vld;
    logic              w_wr1_vld;
    bpu_update_t       w_wr0_dat;
    bpu_update_t       w_wr1_dat;

    // br_i is only taken while idle with room for a full pair of updates.
    // rst_n gating keeps the combinational pulses quiet while in reset.
    assign w_stall  = (r_state != IDLE) || (w_free < FREE_W'(2));
    assign w_accept = rst_n && !w_stall;

    assign w_mis0  = w_accept && is_mispredict(bus.br_i[0]);
    assign w_mis1  = w_accept && is_mispredict(bus.br_i[1]);
    assign w_push0 = w_accept && bus.br_i[0].valid;
    // An older mispredict makes pipe 1 wrong-path: it is neither trained nor counted.
    assign w_push1 = w_accept && bus.br_i[1].valid && !w_mis0;

    // Compact the accepted branches into FIFO slots, oldest first.
    assign w_wr0_vld = w_push0 || w_push1;
    assign w_wr1_vld = w_push0 && w_push1;
    assign w_wr0_dat = w_push0 ? to_update(bus.br_i[0]) : to_update(bus.br_i[1]);
    assign w_wr1_dat = to_update(bus.br_i[1]);

    assign bus.stall_o          = w_stall;
    assign bus.flush_o          = w_mis0 || w_mis1;
    // Pipe 1 may hold a non-branch younger instruction, so kill whenever pipe 0 mispredicts.
    assign bus.kill_younger_o   = w_mis0;
    assign bus.redirect_valid_o = r_redirect_valid;
    assign bus.redirect_pc_o    = r_redirect_pc;

    branch_update_fifo #(
        .DEPTH (UPD_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wr0_vld (w_wr0_vld),
        .i_wr0_dat (w_wr0_dat),
        .i_wr1_vld (w_wr1_vld),
        .i_wr1_dat (w_wr1_dat),
        .o_rd_vld  (bus.upd_valid_o),
        .o_rd_dat  (bus.upd_o),
        .i_rd_rdy  (bus.upd_ready_i),
        .o_free    (w_free)
    );

    // Redirect FSM: capture target, hold it until the frontend takes it, then drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= IDLE;
            r_cnt            <= '0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_mis0 || w_mis1) begin
                        r_redirect_pc    <= w_mis0 ? redirect_target(bus.br_i[0])
                                                   : redirect_target(bus.br_i[1]);
                        r_redirect_valid <= 1'b1;
                        r_state          <= REDIR;
                    end
                end
                REDIR: begin
                    if (bus.redirect_ready_i) begin
                        r_redirect_valid <= 1'b0;
                        r_cnt            <= CNT_W'(DRAIN_CYCLES - 1);
                        r_state          <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (r_cnt == '0) r_state <= IDLE;
                    else             r_cnt   <= r_cnt - CNT_W'(1);
                end
                default: begin
                    r_state          <= IDLE;
                    r_redirect_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef BRANCH_PERF_CNT_EN
    logic [31:0] r_perf_br;
    logic [31:0] r_perf_mis;
    logic [1:0]  w_br_inc;
    logic [1:0]  w_mis_inc;

    assign w_br_inc  = {1'b0, w_push0} + {1'b0, w_push1};
    assign w_mis_inc = {1'b0, w_mis0} + {1'b0, w_mis1 && w_push1};

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [1:0] inc);
        logic [32:0] s;
        s = {1'b0, a} + {31'b0, inc};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    // Saturating counters of accepted branches and accepted mispredicts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_br  <= '0;
            r_perf_mis <= '0;
        end else begin
            r_perf_br  <= sat_add(r_perf_br, w_br_inc);
            r_perf_mis <= sat_add(r_perf_mis, w_mis_inc);
        end
    end

    assign bus.perf_branch_cnt_o  = r_perf_br;
    assign bus.perf_mispred_cnt_o = r_perf_mis;
`else
    assign bus.perf_branch_cnt_o  = '0;
    assign bus.perf_mispred_cnt_o = '0;
`endif

endmodule

// File: doc/branch_redirect_ctrl.md
BRANCH_REDIRECT_CTRL -- requirements
Module: branch_redirect_ctrl

Interface
REQ-001 SHALL have parameter UPD_DEPTH, 4, entries in the branch-predictor update FIFO (power of 2, at least 2).
REQ-002 SHALL have parameter DRAIN_CYCLES, 3, cycles to hold off after a redirect is accepted.
REQ-003 SHALL have port clk, in, 1, the single clock.
REQ-004 SHALL have port rst_n, in, 1, asynchronous active-low reset.
REQ-005 SHALL have port br_i, in, 2 x branch_resolve_t: valid, pc[31:0], taken, target[31:0], pred_taken, pred_target[31:0]; index 0 is older.
REQ-006 SHALL have port stall_o, out, 1: execute must hold br_i while high.
REQ-007 SHALL have ports redirect_valid_o (out, 1), redirect_pc_o (out, 32) and redirect_ready_i (in, 1), forming the frontend redirect handshake.
REQ-008 SHALL have port flush_o, out, 1: one-cycle pipeline squash pulse.
REQ-009 SHALL have port kill_younger_o, out, 1: pipe-1 result is wrong-path.
REQ-010 SHALL have port upd_o, out, bpu_update_t: pc, taken, target, mispredict; plus upd_valid_o (out, 1) and upd_ready_i (in, 1).
REQ-011 SHALL have ports perf_branch_cnt_o and perf_mispred_cnt_o, out, 32 each.

Function
REQ-012 SHALL flag pipe i mispredicted when valid, and either taken != pred_taken or (taken and target != pred_target).
REQ-013 SHALL give pipe 0 priority: if pipe 0 mispredicts, pipe 1 is dropped (not enqueued) and kill_younger_o is pulsed in the same cycle.
REQ-014 SHALL use FSM states IDLE, REDIR and DRAIN.
REQ-015 SHALL sample br_i only in IDLE with stall_o low; br_i is ignored in REDIR/DRAIN.
REQ-016 SHALL, in IDLE on a mispredict, pulse flush_o combinationally in the detection cycle, register redirect_pc, and enter REDIR next cycle.
REQ-017 SHALL set redirect_pc to target if taken, else pc+4; 32-bit wrap, no carry-out.
REQ-018 SHALL, in REDIR, hold redirect_valid_o high and redirect_pc_o stable until redirect_ready_i; on the handshake cycle, load the counter with DRAIN_CYCLES-1 and enter DRAIN.
REQ-019 SHALL, in DRAIN, decrement the counter each cycle and enter IDLE the cycle after it reads 0; DRAIN_CYCLES=1 gives exactly one DRAIN cycle.
REQ-020 SHALL assert stall_o = (state != IDLE) or (FIFO free entries < 2).
REQ-021 SHALL enqueue every accepted valid branch (pipe 0 before pipe 1) in the FIFO, 0, 1 or 2 per cycle, with the mispredict bit set per REQ-012.
REQ-022 SHALL drive upd_valid_o = FIFO non-empty, head on upd_o; pop on upd_valid_o and upd_ready_i.
REQ-023 SHALL allow simultaneous push and pop, with count updated by push minus pop.
REQ-024 SHALL keep the FIFO from overflowing or underflowing by construction; push while free < 2 is impossible because of stall_o.
REQ-025 SHALL, when both pipes are correct, keep the state IDLE and produce no flush or redirect.

Reset
REQ-026 SHALL, on rst_n low, asynchronously set state IDLE, FIFO empty, drain counter 0, redirect_pc_o 0 and perf counters 0.
REQ-027 SHALL hold all outputs low during reset.
REQ-028 SHALL, on reset mid-REDIR, abandon the pending redirect; no pulse may occur after release.

Configuration
REQ-029 SHALL use macro BRANCH_PERF_CNT_EN.
REQ-030 SHALL, when BRANCH_PERF_CNT_EN is defined, count accepted valid branches and accepted mispredicts in saturating 32-bit counters.
REQ-031 SHALL count a dropped pipe-1 branch in neither counter.
REQ-032 SHALL, when BRANCH_PERF_CNT_EN is undefined, tie both perf ports to 0, with no counter flops.

Structure
REQ-033 SHALL place branch_resolve_t, bpu_update_t and the redirect FSM state enum in pipeline_types.
REQ-034 SHALL implement the FIFO as sub-module branch_update_fifo: 2-write / 1-read, UPD_DEPTH entries, pointer wrap modulo UPD_DEPTH.

Verification
REQ-035 SHALL test pipe0 {pc=0x1C000000, taken=1, target=0x1C000040, pred_taken=0}: flush_o pulses the same cycle; next cycle redirect_valid_o=1 with redirect_pc_o=0x1C000040; FIFO gains one entry with mispredict=1.
REQ-036 SHALL test the same case plus a valid pipe-1 branch: kill_younger_o=1 and only one FIFO entry is added.
REQ-037 SHALL test pipe0 correct plus pipe1 {pc=0x100, taken=0, pred_taken=1}: redirect_pc_o=0x104 and two entries are enqueued in order.
REQ-038 SHALL test redirect_ready_i held low for 5 cycles: redirect_valid_o and redirect_pc_o stay stable; after ready, DRAIN lasts 3 cycles, then stall_o drops.
REQ-039 SHALL test upd_ready_i=0 with 3 correct branches accepted: stall_o rises at count 3 (free=1); one pop drops stall_o the next cycle.
REQ-040 SHALL test rst_n low for one cycle during REDIR: the state is IDLE, redirect_valid_o=0 and the FIFO is empty immediately after.
